// File: rtl/gru_pkg.sv
// Shared GRU datapath constants and the bank state type used by the input packer.
package gru_pkg;

   localparam int unsigned FIXED_W    = 32;
   localparam int unsigned VAD_NB     = 24;
   localparam int unsigned NOISE_NB   = 90;
   localparam int unsigned DENOISE_NB = 114;

   typedef enum logic [1:0] {
      BANK_EMPTY   = 2'd0,
      BANK_FILLING = 2'd1,
      BANK_FULL    = 2'd2
   } bank_state_e;

endpackage

// File: rtl/gru_vec_bank.sv
// One vector bank: NB_INPUTS packed elements plus its fill state register.
module gru_vec_bank
   import gru_pkg::*;
#(
   parameter int unsigned FIXED     = FIXED_W,
   parameter int unsigned NB_INPUTS = VAD_NB,
   parameter int unsigned CNT_W     = $clog2(NB_INPUTS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       wr_en,
   input  logic [CNT_W-1:0]           wr_idx,
   input  logic [FIXED-1:0]           wr_data,
   input  bank_state_e                state_d,
   output bank_state_e                state,
   output logic [NB_INPUTS*FIXED-1:0] data
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= BANK_EMPTY;
         data  <= '0;
      end else begin
         state <= state_d;
         for (int unsigned i = 0; i < NB_INPUTS; i++) begin
            if (wr_en && (wr_idx == CNT_W'(i)))
               data[i*FIXED +: FIXED] <= wr_data;
         end
      end
   end

endmodule

// File: rtl/gru_input_packer.sv
// Double-buffered serial-to-parallel packer feeding a GRU input vector port.
// Bank A is select value 0, bank B is select value 1.
module gru_input_packer
   import gru_pkg::*;
#(
   parameter int unsigned FIXED     = FIXED_W,
   parameter int unsigned NB_INPUTS = VAD_NB,
   parameter int unsigned CNT_W     = $clog2(NB_INPUTS)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [FIXED-1:0]           in_data,
   input  logic                       in_valid,
   input  logic                       in_last,
   output logic                       in_ready,
   output logic [NB_INPUTS*FIXED-1:0] vec_out,
   output logic                       vec_valid,
   input  logic                       vec_ready,
   output logic                       frame_err
);

   logic [CNT_W-1:0]           idx;
   logic                       wr_sel;
   logic                       rd_sel;
   bank_state_e                st_a, st_b, st_a_d, st_b_d;
   bank_state_e                wr_st, rd_st, fill_st;
   logic [NB_INPUTS*FIXED-1:0] data_a, data_b;
   logic                       beat_acc, vec_acc, idx_last, err_d;

   assign wr_st     = wr_sel ? st_b : st_a;
   assign rd_st     = rd_sel ? st_b : st_a;
   assign in_ready  = rst_n && (wr_st != BANK_FULL);
   assign vec_valid = (rd_st == BANK_FULL);
   assign vec_out   = rd_sel ? data_b : data_a;
   assign beat_acc  = in_valid && in_ready;
   assign vec_acc   = vec_valid && vec_ready;
   assign idx_last  = (idx == CNT_W'(NB_INPUTS - 1));
   assign err_d     = beat_acc && (idx_last ? !in_last : in_last);

   // Bank next-state; a bank cannot be both filling target and accepted vector in one cycle.
   always_comb begin
      st_a_d  = st_a;
      st_b_d  = st_b;
      fill_st = BANK_FILLING;
      if (idx_last)
         fill_st = BANK_FULL;
      else if (in_last)
         fill_st = BANK_EMPTY;
      if (vec_acc) begin
         if (rd_sel) st_b_d = BANK_EMPTY;
         else        st_a_d = BANK_EMPTY;
      end
      if (beat_acc) begin
         if (wr_sel) st_b_d = fill_st;
         else        st_a_d = fill_st;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx       <= '0;
         wr_sel    <= 1'b0;
         rd_sel    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err_d;
         if (beat_acc)
            idx <= (idx_last || in_last) ? '0 : idx + CNT_W'(1);
         if (beat_acc && idx_last)
            wr_sel <= ~wr_sel;
         if (vec_acc)
            rd_sel <= ~rd_sel;
      end
   end

   gru_vec_bank #(.FIXED(FIXED), .NB_INPUTS(NB_INPUTS), .CNT_W(CNT_W)) u_bank_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (beat_acc && !wr_sel),
      .wr_idx  (idx),
      .wr_data (in_data),
      .state_d (st_a_d),
      .state   (st_a),
      .data    (data_a)
   );

   gru_vec_bank #(.FIXED(FIXED), .NB_INPUTS(NB_INPUTS), .CNT_W(CNT_W)) u_bank_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (beat_acc && wr_sel),
      .wr_idx  (idx),
      .wr_data (in_data),
      .state_d (st_b_d),
      .state   (st_b),
      .data    (data_b)
   );

endmodule

// File: tb/tb_gru_input_packer.sv
// Bench for gru_input_packer: queue-of-vectors reference model plus directed and random traffic.
module tb_gru_input_packer;
   import gru_pkg::*;

   localparam int unsigned FIXED = FIXED_W;
   localparam int unsigned NB    = VAD_NB;
   localparam int unsigned CW    = $clog2(NB);
   localparam int unsigned VW    = NB * FIXED;

   typedef logic [VW-1:0] vec_t;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [FIXED-1:0] in_data;
   logic             in_valid, in_last, in_ready;
   vec_t             vec_out;
   logic             vec_valid, vec_ready, frame_err;

   int checks = 0;
   int errors = 0;

   // Reference model: completed vectors awaiting consumption, plus the frame being assembled.
   vec_t q[$];
   vec_t fill;
   int   cnt;
   logic exp_err;

   always #5 clk = ~clk;

   gru_input_packer #(.FIXED(FIXED), .NB_INPUTS(NB), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .vec_out   (vec_out),
      .vec_valid (vec_valid),
      .vec_ready (vec_ready),
      .frame_err (frame_err)
   );

   task automatic chk(input string name, input vec_t act, input vec_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_outputs();
      chk("in_ready", vec_t'(in_ready), vec_t'(rst_n && (q.size() < 2)));
      chk("vec_valid", vec_t'(vec_valid), vec_t'(q.size() > 0));
      if (q.size() > 0)
         chk("vec_out", vec_out, q[0]);
      chk("frame_err", vec_t'(frame_err), vec_t'(exp_err));
   endtask

   function automatic logic [FIXED-1:0] elem(input int i);
      return vec_out[i*FIXED +: FIXED];
   endfunction

   // Drive one cycle from the falling edge, advance the model at the rising edge, check at the next fall.
   task automatic cycle(input logic v, input logic [FIXED-1:0] d, input logic l,
                        input logic vr, input logic r = 1'b1);
      logic acc_in, acc_vec;
      rst_n     = r;
      in_valid  = v;
      in_data   = d;
      in_last   = l;
      vec_ready = vr;
      acc_in  = r && v && (q.size() < 2);
      acc_vec = r && vr && (q.size() > 0);
      @(posedge clk);
      exp_err = 1'b0;
      if (!r) begin
         q.delete();
         cnt  = 0;
         fill = '0;
      end else begin
         if (acc_vec) void'(q.pop_front());
         if (acc_in) begin
            fill[cnt*FIXED +: FIXED] = d;
            if (cnt == NB - 1) begin
               q.push_back(fill);
               cnt     = 0;
               exp_err = !l;
            end else if (l) begin
               cnt     = 0;
               exp_err = 1'b1;
            end else begin
               cnt++;
            end
         end
      end
      @(negedge clk);
      compare_outputs();
   endtask

   task automatic frame(input int base, input logic vr, input int n = NB, input int last_at = NB - 1);
      for (int i = 0; i < n; i++)
         cycle(1'b1, FIXED'(base + i), i == last_at, vr);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; vec_ready = 1'b0;
      cnt = 0; fill = '0; exp_err = 1'b0;
      @(negedge clk);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("reset_vec_out", vec_out, '0);
      chk("reset_in_ready_low", vec_t'(in_ready), '0);
      cycle(1'b0, '0, 1'b0, 1'b0);
      chk("release_in_ready", vec_t'(in_ready), vec_t'(1));

      // 1: single frame, values 1..24
      frame(1, 1'b1);
      chk("t1_valid", vec_t'(vec_valid), vec_t'(1));
      chk("t1_elem0", vec_t'(elem(0)), vec_t'(1));
      chk("t1_elem23", vec_t'(elem(23)), vec_t'(24));
      drain();

      // 2: both banks fill with consumer stalled
      frame(1, 1'b0);
      frame(25, 1'b0);
      chk("t2_ready_low", vec_t'(in_ready), '0);
      chk("t2_bankA_elem0", vec_t'(elem(0)), vec_t'(1));
      cycle(1'b0, '0, 1'b0, 1'b1);
      chk("t2_bankB_elem0", vec_t'(elem(0)), vec_t'(25));
      chk("t2_bankB_elem23", vec_t'(elem(23)), vec_t'(48));
      chk("t2_ready_back", vec_t'(in_ready), vec_t'(1));
      drain();

      // 3: completion of one bank coincides with accept of the other
      frame(200, 1'b0);
      frame(224, 1'b0, NB - 1);
      cycle(1'b1, FIXED'(247), 1'b1, 1'b1);
      chk("t3_valid", vec_t'(vec_valid), vec_t'(1));
      chk("t3_elem0", vec_t'(elem(0)), vec_t'(224));
      chk("t3_elem23", vec_t'(elem(23)), vec_t'(247));
      drain();

      // 4: early in_last discards the partial frame
      frame(50, 1'b0, 11, 10);
      chk("t4_frame_err", vec_t'(frame_err), vec_t'(1));
      chk("t4_no_valid", vec_t'(vec_valid), '0);
      frame(100, 1'b0);
      chk("t4_elem0", vec_t'(elem(0)), vec_t'(100));
      drain();

      // 5: missing in_last still completes the vector
      frame(300, 1'b0, NB, -1);
      chk("t5_frame_err", vec_t'(frame_err), vec_t'(1));
      chk("t5_elem23", vec_t'(elem(23)), vec_t'(323));
      drain();

      // 6: reset while one vector is presented and another half-filled
      frame(400, 1'b0);
      frame(500, 1'b0, 12);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("t6_valid_low", vec_t'(vec_valid), '0);
      chk("t6_vec_out_zero", vec_out, '0);
      frame(1000, 1'b0);
      chk("t6_elem0", vec_t'(elem(0)), vec_t'(1000));
      drain();

      // Random traffic with occasional framing faults and resets.
      for (int n = 0; n < 4000; n++) begin
         logic v, l, vr, r;
         v  = ($urandom_range(0, 99) < 80);
         vr = ($urandom_range(0, 99) < 40);
         l  = (cnt == NB - 1);
         if ($urandom_range(0, 99) < 3) l = !l;
         r  = ($urandom_range(0, 999) != 0);
         cycle(v, FIXED'($urandom), l, vr, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
